pipe_control_unit: RTL and testbench

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

---
 rtl/pipe_control_unit.sv | 159 +++++++++++++++
 tb/tb_pipe_control_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit.sv
// Pipeline control unit: opcode decode, ID->EX->MEM->WB control shifting, load-use stall and IF/ID flush.
// Define PIPE_CTRL_HAZARD_EN to enable load-use stall detection and the stall counter.
module pipe_control_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_wreg,
  input  logic             br_taken,
  output logic             stall,
  output logic             ifid_flush,
  output logic             ex_RegDst,
  output logic             ex_ALUSrc,
  output logic             ex_Branch_Beq,
  output logic             ex_Branch_Bne,
  output logic             ex_jump,
  output logic [1:0]       ex_ALUOp,
  output logic             mem_MemRead,
  output logic             mem_MemWrite,
  output logic             wb_MemtoReg,
  output logic             wb_RegWrite,
  output logic [REG_W-1:0] wb_wreg,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       beq;
    logic       bne;
    logic       jump;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  ctrl_t            dec;
  logic             dec_known;
  ctrl_t            idex_d, idex_q;
  logic [REG_W-1:0] idex_wreg_d, idex_wreg_q;
  logic             exmem_mem_read_q, exmem_mem_write_q, exmem_mem_to_reg_q, exmem_reg_write_q;
  logic [REG_W-1:0] exmem_wreg_q;
  logic             memwb_mem_to_reg_q, memwb_reg_write_q;
  logic [REG_W-1:0] memwb_wreg_q;

  always_comb begin
    dec       = '0;
    dec_known = 1'b1;
    case (opcode)
      OP_R:    begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b10; end
      OP_ADDI: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b00; end
      OP_LW:   begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_op     = 2'b00;
      end
      OP_SW:   begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.alu_op = 2'b00; end
      OP_ANDI: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b11; end
      OP_BEQ:  begin dec.beq = 1'b1; dec.alu_op = 2'b01; end
      OP_BNE:  begin dec.bne = 1'b1; dec.alu_op = 2'b01; end
      OP_J:    begin dec.jump = 1'b1; end
      default: dec_known = 1'b0;
    endcase
  end

`ifdef PIPE_CTRL_HAZARD_EN
  logic uses_rt;
  logic hazard;
  logic [CNT_W-1:0] stall_count_q;

  // rt is only a true source operand for R-type, sw and the branches.
  assign uses_rt = (opcode == OP_R) || (opcode == OP_SW) ||
                   (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign hazard  = idex_q.mem_read && (idex_wreg_q != '0) &&
                   ((idex_wreg_q == id_rs) || ((idex_wreg_q == id_rt) && uses_rt));
  assign stall   = hazard && !br_taken && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count_q <= '0;
    else if (stall && (stall_count_q != '1))
      stall_count_q <= stall_count_q + 1'b1;
  end
  assign stall_count = stall_count_q;
`else
  logic hazard_unused;
  assign hazard_unused = ^{id_rs, id_rt};
  assign stall         = 1'b0;
  assign stall_count   = '0;
`endif

  assign ifid_flush = !reset && (br_taken || ((opcode == OP_J) && !stall));

  // Unknown opcodes become a full bubble, destination index included.
  always_comb begin
    idex_d      = dec;
    idex_wreg_d = dec_known ? id_wreg : '0;
    if (br_taken || stall) begin
      idex_d      = '0;
      idex_wreg_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q             <= '0;
      idex_wreg_q        <= '0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_reg_write_q  <= 1'b0;
      exmem_wreg_q       <= '0;
      memwb_mem_to_reg_q <= 1'b0;
      memwb_reg_write_q  <= 1'b0;
      memwb_wreg_q       <= '0;
    end else begin
      idex_q             <= idex_d;
      idex_wreg_q        <= idex_wreg_d;
      exmem_mem_read_q   <= idex_q.mem_read;
      exmem_mem_write_q  <= idex_q.mem_write;
      exmem_mem_to_reg_q <= idex_q.mem_to_reg;
      exmem_reg_write_q  <= idex_q.reg_write;
      exmem_wreg_q       <= idex_wreg_q;
      memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
      memwb_reg_write_q  <= exmem_reg_write_q;
      memwb_wreg_q       <= exmem_wreg_q;
    end
  end

  assign ex_RegDst     = idex_q.reg_dst;
  assign ex_ALUSrc     = idex_q.alu_src;
  assign ex_Branch_Beq = idex_q.beq;
  assign ex_Branch_Bne = idex_q.bne;
  assign ex_jump       = idex_q.jump;
  assign ex_ALUOp      = idex_q.alu_op;
  assign mem_MemRead   = exmem_mem_read_q;
  assign mem_MemWrite  = exmem_mem_write_q;
  assign wb_MemtoReg   = memwb_mem_to_reg_q;
  assign wb_RegWrite   = memwb_reg_write_q;
  assign wb_wreg       = memwb_wreg_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: stimulus pushes expected output snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_control_unit;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (2 ** CNT_W) - 1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BUB  = 6'b111111;

`ifdef PIPE_CTRL_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       opcode = 6'd0;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, id_wreg = '0;
  logic             br_taken = 1'b0;
  logic             stall, ifid_flush;
  logic             ex_RegDst, ex_ALUSrc, ex_Branch_Beq, ex_Branch_Bne, ex_jump;
  logic [1:0]       ex_ALUOp;
  logic             mem_MemRead, mem_MemWrite, wb_MemtoReg, wb_RegWrite;
  logic [REG_W-1:0] wb_wreg;
  logic [CNT_W-1:0] stall_count;

  pipe_control_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_wreg(id_wreg), .br_taken(br_taken), .stall(stall), .ifid_flush(ifid_flush),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_Branch_Beq(ex_Branch_Beq),
    .ex_Branch_Bne(ex_Branch_Bne), .ex_jump(ex_jump), .ex_ALUOp(ex_ALUOp),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_RegWrite(wb_RegWrite), .wb_wreg(wb_wreg), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [21:0] exp_q[$];

  // Model: which instruction sits in each stage (0=EX, 1=MEM, 2=WB) and its destination.
  logic [5:0]       m_op[3];
  logic [REG_W-1:0] m_wr[3];
  int               m_cnt;

  // Control table: {RegDst,ALUSrc,Beq,Bne,jump,ALUOp[1:0],MemRead,MemWrite,MemtoReg,RegWrite}
  function automatic logic [10:0] ctl(input logic [5:0] op);
    case (op)
      OP_R:    return 11'b1_0_0_0_0_10_0_0_0_1;
      OP_ADDI: return 11'b0_1_0_0_0_00_0_0_0_1;
      OP_LW:   return 11'b0_1_0_0_0_00_1_0_1_1;
      OP_SW:   return 11'b0_1_0_0_0_00_0_1_0_0;
      OP_ANDI: return 11'b0_1_0_0_0_11_0_0_0_1;
      OP_BEQ:  return 11'b0_0_1_0_0_01_0_0_0_0;
      OP_BNE:  return 11'b0_0_0_1_0_01_0_0_0_0;
      OP_J:    return 11'b0_0_0_0_1_00_0_0_0_0;
      default: return 11'b0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_op[i] = OP_BUB;
      m_wr[i] = '0;
    end
    m_cnt = 0;
  endtask

  task automatic step(input logic [5:0] op, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                      input logic [REG_W-1:0] wr, input logic bt, input logic rst, output logic stalled);
    logic haz, st, fl;
    logic [10:0] ce, cm, cw;
    logic [21:0] e;
    @(posedge clk);
    #1;
    reset = rst; opcode = op; id_rs = rs; id_rt = rt; id_wreg = wr; br_taken = bt;
    st = 1'b0;
    if (rst) begin
      model_clear();
      e = '0;
    end else begin
      ce  = ctl(m_op[0]);
      cm  = ctl(m_op[1]);
      cw  = ctl(m_op[2]);
      haz = HAZ_EN && ce[3] && (m_wr[0] != 0) &&
            ((m_wr[0] == rs) || ((m_wr[0] == rt) && (op inside {OP_R, OP_SW, OP_BEQ, OP_BNE})));
      st  = haz && !bt;
      fl  = bt || ((op == OP_J) && !st);
      e   = {st, fl, ce[10:4], cm[3:2], cw[1:0], m_wr[2], CNT_W'(m_cnt)};
      m_op[2] = m_op[1]; m_wr[2] = m_wr[1];
      m_op[1] = m_op[0]; m_wr[1] = m_wr[0];
      if (st || bt) begin
        m_op[0] = OP_BUB; m_wr[0] = '0;
      end else begin
        m_op[0] = op; m_wr[0] = wr;
      end
      if (st && m_cnt < CNT_MAX) m_cnt++;
    end
    exp_q.push_back(e);
    stalled = st;
  endtask

  // Issue one instruction, holding it in ID while the model says the pipe is stalled.
  task automatic issue(input logic [5:0] op, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic [REG_W-1:0] wr, input logic bt);
    logic s;
    int n;
    n = 0;
    step(op, rs, rt, wr, bt, 1'b0, s);
    while (s && n < 8) begin
      step(op, rs, rt, wr, 1'b0, 1'b0, s);
      n++;
    end
  endtask

  initial begin
    logic [21:0] e, g;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = {stall, ifid_flush, ex_RegDst, ex_ALUSrc, ex_Branch_Beq, ex_Branch_Bne, ex_jump,
             ex_ALUOp, mem_MemRead, mem_MemWrite, wb_MemtoReg, wb_RegWrite, wb_wreg, stall_count};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL outputs cycle=%0d got=%h expected=%h (rst=%b op=%b bt=%b)",
                   cyc, g, e, reset, opcode, br_taken);
        end else begin
          $display("ok outputs cycle=%0d value=%h (rst=%b op=%b bt=%b)", cyc, g, reset, opcode, br_taken);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic s;
    logic [5:0] ops[8];
    logic [5:0] op;
    logic [REG_W-1:0] rs, rt, wr;
    logic bt, rst;
    ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_ANDI, OP_BEQ, OP_BNE, OP_J};
    model_clear();

    step(OP_R, 0, 0, 0, 1'b0, 1'b1, s);
    step(OP_R, 0, 0, 0, 1'b0, 1'b1, s);

    // Release with R-type in ID, then walk it to write-back.
    issue(OP_R, 1, 2, 3, 1'b0);
    issue(OP_ADDI, 4, 5, 6, 1'b0);
    issue(OP_ANDI, 7, 1, 2, 1'b0);
    issue(OP_BEQ, 1, 2, 0, 1'b0);
    issue(OP_BNE, 3, 4, 0, 1'b0);

    // Load-use on rs, then a load to $0 that must not stall.
    issue(OP_LW, 1, 0, 8, 1'b0);
    issue(OP_R, 8, 2, 9, 1'b0);
    issue(OP_LW, 1, 0, 0, 1'b0);
    issue(OP_R, 0, 0, 4, 1'b0);

    // rt only counts for R/sw/beq/bne.
    issue(OP_LW, 1, 0, 5, 1'b0);
    issue(OP_ADDI, 1, 5, 6, 1'b0);
    issue(OP_LW, 1, 0, 5, 1'b0);
    issue(OP_SW, 2, 5, 0, 1'b0);
    issue(OP_LW, 1, 0, 7, 1'b0);
    issue(OP_BNE, 3, 7, 0, 1'b0);

    // Taken branch coincident with a load-use hazard, then a jump.
    issue(OP_LW, 1, 0, 8, 1'b0);
    step(OP_R, 8, 0, 9, 1'b1, 1'b0, s);
    issue(OP_J, 0, 0, 0, 1'b0);
    issue(OP_R, 1, 1, 1, 1'b0);

    // Async reset while sw sits in EX/MEM.
    issue(OP_SW, 1, 2, 3, 1'b0);
    issue(OP_R, 3, 3, 3, 1'b0);
    step(OP_R, 0, 0, 0, 1'b0, 1'b1, s);
    step(OP_R, 0, 0, 0, 1'b0, 1'b1, s);
    issue(OP_LW, 2, 0, 4, 1'b0);

    // Drive more hazards than the counter can hold.
    for (int i = 0; i < (2 ** CNT_W) + 3; i++) begin
      issue(OP_LW, 1, 0, 8, 1'b0);
      issue(OP_R, 8, 8, 9, 1'b0);
    end

    s = 1'b0;
    op = OP_R; rs = '0; rt = '0; wr = '0;
    for (int i = 0; i < 300; i++) begin
      if (!s) begin
        op = ops[$urandom_range(0, 7)];
        rs = REG_W'($urandom_range(0, 3));
        rt = REG_W'($urandom_range(0, 3));
        wr = REG_W'($urandom_range(0, 3));
      end
      bt  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 59) == 0);
      step(op, rs, rt, wr, bt, rst, s);
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
